// File: rtl/cache_pkg.sv
// Shared cache geometry defaults and types for the L2 set datapath.
package cache_pkg;

    localparam int LINE_SIZE  = 512;
    localparam int WAYS       = 8;
    localparam int BEAT_WIDTH = 64;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} wlw_state_t;

    typedef logic [LINE_SIZE-1:0] line_t;

endpackage

// File: rtl/way_decoder.sv
// Binary way index to one-hot strobe; flags indices beyond the way count.
module way_decoder
    import cache_pkg::*;
#(
    parameter int N = WAYS,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [W-1:0] i_sel,
    output logic [N-1:0] o_onehot,
    output logic         o_oor
);

    always_comb begin
        o_onehot = '0;
        o_oor    = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(i_sel) == i) begin
                o_onehot[i] = 1'b1;
                o_oor       = 1'b0;
            end
        end
    end

endmodule

// File: rtl/way_line_writer.sv
// Assembles fill-bus beats into a cache line and strobes it into one way.
module way_line_writer
    import cache_pkg::*;
#(
    parameter int  lineSize  = LINE_SIZE,
    parameter int  ways      = WAYS,
    parameter int  beatWidth = BEAT_WIDTH,
    localparam int BEATS     = lineSize / beatWidth,
    localparam int WAY_W     = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fill_valid,
    output logic                 fill_ready,
    input  logic [beatWidth-1:0] fill_data,
    input  logic [WAY_W-1:0]     fill_way,
    input  logic                 fill_abort,
    output logic [ways-1:0]      way_we,
    output logic [lineSize-1:0]  line_out,
    output logic                 fill_err
);

    localparam int CNT_W = $clog2(BEATS + 1);

    if (lineSize % beatWidth != 0) begin : g_bad_geometry
        $error("way_line_writer: lineSize must be a multiple of beatWidth");
    end

    wlw_state_t           r_state;
    wlw_state_t           w_state_nxt;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_slot;
    logic [WAY_W-1:0]     r_way_q;
    logic [WAY_W-1:0]     w_way_nxt;
    logic [lineSize-1:0]  r_line_q;
    logic [ways-1:0]      r_way_we;
    logic                 r_fill_err;
    logic [ways-1:0]      w_onehot;
    logic                 w_oor;
    logic                 w_xfer;

    assign fill_ready = (r_state != WRITE) && !fill_abort;
    assign w_xfer     = fill_valid && fill_ready;
    assign w_slot     = (r_state == IDLE) ? '0 : r_beat_cnt;
    assign w_way_nxt  = (r_state == IDLE && w_xfer) ? fill_way : r_way_q;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (fill_abort) begin
                    w_cnt_nxt = '0;
                end else if (w_xfer) begin
                    w_state_nxt = (BEATS == 1) ? WRITE : COLLECT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            COLLECT: begin
                if (fill_abort) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    if (r_beat_cnt == CNT_W'(BEATS - 1)) begin
                        w_state_nxt = WRITE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Decode the way that will be held during WRITE so the strobe registers with the state.
    way_decoder #(
        .N(ways),
        .W(WAY_W)
    ) u_way_decoder (
        .i_sel   (w_way_nxt),
        .o_onehot(w_onehot),
        .o_oor   (w_oor)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_way_q    <= '0;
            r_line_q   <= '0;
            r_way_we   <= '0;
            r_fill_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_way_q    <= w_way_nxt;
            r_way_we   <= (w_state_nxt == WRITE) ? w_onehot : '0;
            r_fill_err <= (w_state_nxt == WRITE) && w_oor;
            for (int unsigned s = 0; s < BEATS; s++) begin
                if (w_xfer && w_slot == CNT_W'(s)) begin
                    r_line_q[s*beatWidth +: beatWidth] <= fill_data;
                end
            end
        end
    end

    assign way_we   = r_way_we;
    assign fill_err = r_fill_err;
    assign line_out = r_line_q;

endmodule

// File: tb/tb_way_line_writer.sv
// Drives an 8-way and a 6-way writer with shared stimulus against a beat-level line model.
module tb_way_line_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fill_valid;
    logic         fill_abort;
    logic [63:0]  fill_data;
    logic [2:0]   fill_way;
    logic         rdy8, rdy6;
    logic [7:0]   we8;
    logic [5:0]   we6;
    logic [511:0] line8, line6;
    logic         err8, err6;

    always #5 clk = ~clk;

    way_line_writer #(.lineSize(512), .ways(8), .beatWidth(64)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .fill_valid(fill_valid), .fill_ready(rdy8),
        .fill_data(fill_data), .fill_way(fill_way), .fill_abort(fill_abort),
        .way_we(we8), .line_out(line8), .fill_err(err8)
    );

    way_line_writer #(.lineSize(512), .ways(6), .beatWidth(64)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .fill_valid(fill_valid), .fill_ready(rdy6),
        .fill_data(fill_data), .fill_way(fill_way), .fill_abort(fill_abort),
        .way_we(we6), .line_out(line6), .fill_err(err6)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          m_cnt;
    bit          m_write;
    int          m_way;
    logic [63:0] m_line [8];
    int          strobe_cyc[$];
    logic [7:0]  strobe_way[$];
    int          ready_low;
    int          err6_cnt;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_cnt   = 0;
        m_write = 0;
        m_way   = 0;
        for (int k = 0; k < 8; k++) m_line[k] = '0;
    endfunction

    function automatic logic [511:0] model_line();
        logic [511:0] v;
        for (int k = 0; k < 8; k++) v[k*64 +: 64] = m_line[k];
        return v;
    endfunction

    task automatic tick(output bit acc);
        bit          rdy, ab, vld;
        logic [63:0] d;
        int          w;
        logic [7:0]  e8;
        logic [5:0]  e6;
        @(negedge clk);
        rdy = !m_write && !fill_abort;
        e8  = '0;
        e6  = '0;
        if (m_write && m_way < 8) e8[m_way] = 1'b1;
        if (m_write && m_way < 6) e6[m_way] = 1'b1;
        check("ready8", rdy8, rdy);
        check("ready6", rdy6, rdy);
        check("we8", we8, e8);
        check("we6", we6, e6);
        check("err8", err8, 1'b0);
        check("err6", err6, m_write && m_way >= 6);
        check("line8", line8, model_line());
        check("line6", line6, model_line());
        if (we8 != 0) begin
            strobe_cyc.push_back(cyc);
            strobe_way.push_back(we8);
        end
        if (!rdy8) ready_low++;
        if (err6) err6_cnt++;
        vld = fill_valid;
        ab  = fill_abort;
        d   = fill_data;
        w   = int'(fill_way);
        acc = vld && rdy;
        @(posedge clk);
        cyc++;
        if (m_write) begin
            m_write = 0;
            m_cnt   = 0;
        end else if (ab) begin
            m_cnt = 0;
        end else if (acc) begin
            if (m_cnt == 0) m_way = w;
            m_line[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 8) m_write = 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        fill_valid = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [2:0] w, input int gapmax);
        bit acc;
        if (gapmax > 0) idle($urandom_range(0, gapmax));
        fill_valid = 1'b1;
        fill_data  = d;
        fill_way   = w;
        acc = 0;
        for (int t = 0; t < 4 && !acc; t++) tick(acc);
        check("accept", acc, 1'b1);
    endtask

    task automatic send_partial(input logic [2:0] way, input logic [63:0] base,
                                input int nbeats, input int gapmax);
        for (int k = 0; k < nbeats; k++)
            send_beat(base + 64'(k), (k == 0) ? way : 3'($urandom_range(0, 7)), gapmax);
    endtask

    task automatic send_line(input logic [2:0] way, input logic [63:0] base, input int gapmax);
        send_partial(way, base, 8, gapmax);
    endtask

    task automatic do_reset();
        fill_valid = 1'b0;
        fill_abort = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        check("rst_we8", we8, 8'h00);
        check("rst_err6", err6, 1'b0);
        check("rst_line8", line8, 512'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int base_n;
        rst_n      = 1'b0;
        fill_valid = 1'b0;
        fill_abort = 1'b0;
        fill_data  = '0;
        fill_way   = '0;
        model_reset();
        ready_low = 0;
        err6_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("init_we8", we8, 8'h00);
        check("init_err8", err8, 1'b0);
        check("init_line6", line6, 512'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic fill to way 5
        send_line(3'd5, 64'h1000, 0);
        idle(3);
        check("basic_nstrobe", strobe_cyc.size(), 1);
        check("basic_way", strobe_way[0], 8'b0010_0000);

        // Stalled fills
        for (int i = 0; i < 3; i++) begin
            send_line(3'($urandom_range(0, 7)), {$urandom, $urandom}, 5);
            idle(2);
        end
        check("stall_nstrobe", strobe_cyc.size(), 4);

        // Abort after three beats, then a clean line to way 2
        send_partial(3'd4, 64'hDEAD_0000, 3, 0);
        fill_abort = 1'b1;
        fill_valid = 1'b1;
        fill_data  = 64'hBAD;
        idle(0);
        begin
            bit acc;
            tick(acc);
        end
        fill_abort = 1'b0;
        idle(3);
        check("abort_nostrobe", strobe_cyc.size(), 4);
        send_line(3'd2, 64'h2000, 0);
        idle(2);
        check("abort_next_way", strobe_way[strobe_way.size()-1], 8'b0000_0100);

        // Out-of-range way on the 6-way writer, and first-beat way retention
        err6_cnt = 0;
        send_line(3'd7, 64'h3000, 1);
        idle(3);
        check("range_err6_pulses", err6_cnt, 1);
        send_beat(64'h4000, 3'd1, 0);
        for (int k = 1; k < 8; k++) send_beat(64'h4000 + 64'(k), 3'd7, 0);
        idle(2);
        check("keep_first_way", strobe_way[strobe_way.size()-1], 8'b0000_0010);
        check("keep_no_err6", err6_cnt, 1);

        // Reset in the middle of a line
        base_n = strobe_cyc.size();
        send_partial(3'd3, 64'h5000, 3, 0);
        do_reset();
        send_line(3'd6, 64'h6000, 0);
        idle(2);
        check("post_rst_nstrobe", strobe_cyc.size(), base_n + 1);

        // Back-to-back lines with continuous valid
        strobe_cyc.delete();
        strobe_way.delete();
        ready_low = 0;
        send_line(3'd1, 64'h7000, 0);
        send_line(3'd6, 64'h8000, 0);
        send_line(3'd3, 64'h9000, 0);
        idle(3);
        check("b2b_ready_low", ready_low, 3);
        check("b2b_nstrobe", strobe_cyc.size(), 3);
        if (strobe_cyc.size() == 3) begin
            check("b2b_gap01", strobe_cyc[1] - strobe_cyc[0], 9);
            check("b2b_gap12", strobe_cyc[2] - strobe_cyc[1], 9);
            check("b2b_way0", strobe_way[0], 8'b0000_0010);
            check("b2b_way1", strobe_way[1], 8'b0100_0000);
            check("b2b_way2", strobe_way[2], 8'b0000_1000);
        end

        // Random traffic with occasional aborts
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_partial(3'($urandom_range(0, 7)), {$urandom, $urandom},
                             $urandom_range(1, 6), 2);
                fill_abort = 1'b1;
                fill_valid = 1'($urandom_range(0, 1));
                begin
                    bit acc;
                    tick(acc);
                end
                fill_abort = 1'b0;
            end
            send_line(3'($urandom_range(0, 7)), {$urandom, $urandom}, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
